// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-2 buffered demultiplexer.
// The optional per-channel output counters are enabled by defining DEMUX_CNT_EN.
package demux_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    localparam int CNT_W = 8;

endpackage : demux_pkg

// File: rtl/demux_chan_buf.sv
// One-entry holding register for a single demux output channel with valid/ready output.
// Defining DEMUX_CNT_EN adds a wrapping counter of output handshakes.
module demux_chan_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt
`endif
);

    chan_state_t state;
    chan_state_t state_next;
    logic        pop;

    assign pop = valid & pop_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (push) state_next = FULL;
            FULL:    if (pop && !push) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_comb begin
        valid = (state == FULL);
        ready = (state == EMPTY) | pop_ready;
    end

    // NOTE: the data register is a single word, not a memory, so clearing it on
    // reset is cheap and keeps the output deterministic after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else if (push) begin
            data <= push_data;
        end
    end

`ifdef DEMUX_CNT_EN
    // Counts output handshakes; wraps naturally from all-ones to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (pop) begin
            cnt <= cnt + CNT_W'(1);
        end
    end
`endif

endmodule : demux_chan_buf

// File: rtl/demux1to2_buf.sv
// 1-to-2 demultiplexer with a one-entry buffer per output channel; in_sel picks the channel.
// Defining DEMUX_CNT_EN adds cnt0/cnt1 output-handshake counters.
module demux1to2_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    logic ready0;
    logic ready1;
    logic push0;
    logic push1;

    // Only the addressed channel can stall the input; reset blocks acceptance.
    assign in_ready = ~rst & (in_sel ? ready1 : ready0);
    assign push0    = in_valid & in_ready & ~in_sel;
    assign push1    = in_valid & in_ready & in_sel;

    demux_chan_buf #(.WIDTH(WIDTH)) u_chan0 (
        .clk       (clk),
        .rst       (rst),
        .push      (push0),
        .push_data (in_data),
        .pop_ready (out0_ready),
        .ready     (ready0),
        .valid     (out0_valid),
        .data      (out0_data)
`ifdef DEMUX_CNT_EN
        ,
        .cnt       (cnt0)
`endif
    );

    demux_chan_buf #(.WIDTH(WIDTH)) u_chan1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push1),
        .push_data (in_data),
        .pop_ready (out1_ready),
        .ready     (ready1),
        .valid     (out1_valid),
        .data      (out1_data)
`ifdef DEMUX_CNT_EN
        ,
        .cnt       (cnt1)
`endif
    );

endmodule : demux1to2_buf

// File: tb/tb_demux1to2_buf.sv
// Directed self-checking bench for demux1to2_buf (WIDTH=1); counter checks
// are compiled in when DEMUX_CNT_EN is defined.
module tb_demux1to2_buf;
    import demux_pkg::*;

    localparam int WIDTH = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux1to2_buf #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready)
`ifdef DEMUX_CNT_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic sel, input logic [WIDTH-1:0] d);
        in_valid = valid;
        in_sel   = sel;
        in_data  = d;
        #1;
    endtask

    logic [15:0] pattern;
    logic [WIDTH-1:0] bit_val;

    initial begin
        rst        = 1'b1;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b1);

        // Reset for two cycles with a word presented
        check("rst_in_ready", in_ready, 0);
        step();
        step();
        check("rst_v0", out0_valid, 0);
        check("rst_v1", out1_valid, 0);
        check("rst_d0", out0_data, 0);
        check("rst_d1", out1_data, 0);
        check("rst_in_ready2", in_ready, 0);
`ifdef DEMUX_CNT_EN
        check("rst_cnt0", cnt0, 0);
        check("rst_cnt1", cnt1, 0);
`endif
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        step();
        check("post_rst_v0", out0_valid, 0);
        check("post_rst_v1", out1_valid, 0);

        // Routing: sel/data 0/0, 0/1, 1/0, 1/1 with both outputs ready
        for (int i = 0; i < 4; i++) begin
            logic s;
            logic [WIDTH-1:0] d;
            s = (i >= 2);
            d = WIDTH'(i % 2);
            drive(1'b1, s, d);
            check($sformatf("route%0d_in_ready", i), in_ready, 1);
            step();
            in_valid = 1'b0;
            if (s) begin
                check($sformatf("route%0d_v1", i), out1_valid, 1);
                check($sformatf("route%0d_d1", i), out1_data, d);
                check($sformatf("route%0d_v0", i), out0_valid, 0);
            end else begin
                check($sformatf("route%0d_v0", i), out0_valid, 1);
                check($sformatf("route%0d_d0", i), out0_data, d);
                check($sformatf("route%0d_v1", i), out1_valid, 0);
            end
        end
        drive(1'b0, 1'b0, 1'b0);
        step();
        check("drain_v1", out1_valid, 0);

        // Back-pressure on channel 0; channel 1 keeps flowing
        out0_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b1);
        check("bp_first_ready", in_ready, 1);
        step();
        check("bp_v0", out0_valid, 1);
        check("bp_d0", out0_data, 1);
        drive(1'b1, 1'b0, 1'b0);
        check("bp_second_ready", in_ready, 0);
        step();
        check("bp_hold_v0", out0_valid, 1);
        check("bp_hold_d0", out0_data, 1);
        drive(1'b1, 1'b1, 1'b1);
        check("bp_ch1_ready", in_ready, 1);
        step();
        check("bp_ch1_v1", out1_valid, 1);
        check("bp_ch1_d1", out1_data, 1);
        check("bp_ch1_d0_held", out0_data, 1);
        drive(1'b0, 1'b0, 1'b0);
        out0_ready = 1'b1;
        step();
        check("bp_drain_v0", out0_valid, 0);
        check("bp_drain_v1", out1_valid, 0);

        // Simultaneous push and pop on a full channel 0
        out0_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b0);
        step();
        check("pp_full_v0", out0_valid, 1);
        check("pp_full_d0", out0_data, 0);
        out0_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b1);
        check("pp_in_ready", in_ready, 1);
        step();
        check("pp_v0", out0_valid, 1);
        check("pp_d0", out0_data, 1);
        drive(1'b0, 1'b0, 1'b0);
        step();
        check("pp_empty_v0", out0_valid, 0);

        // Throughput: alternate sel each cycle for 16 words
        pattern = 16'b1011_0010_0111_0100;
        for (int i = 0; i < 16; i++) begin
            logic s;
            s = i[0];
            bit_val = WIDTH'(pattern[i]);
            drive(1'b1, s, bit_val);
            check($sformatf("tp%0d_in_ready", i), in_ready, 1);
            step();
            if (s) begin
                check($sformatf("tp%0d_v1", i), out1_valid, 1);
                check($sformatf("tp%0d_d1", i), out1_data, bit_val);
            end else begin
                check($sformatf("tp%0d_v0", i), out0_valid, 1);
                check($sformatf("tp%0d_d0", i), out0_data, bit_val);
            end
        end
        drive(1'b0, 1'b0, 1'b0);
        step();
        check("tp_drain_v0", out0_valid, 0);
        check("tp_drain_v1", out1_valid, 0);

        // Fresh reset so counters start from a known zero
        rst = 1'b1;
        step();
        rst = 1'b0;
`ifdef DEMUX_CNT_EN
        check("cnt_rst0", cnt0, 0);
        check("cnt_rst1", cnt1, 0);
        // 256 back-to-back words through channel 1
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 1'b1, WIDTH'(i % 2));
            step();
        end
        check("cnt1_255", cnt1, 255);
        drive(1'b0, 1'b0, 1'b0);
        step();
        check("cnt1_wrap", cnt1, 0);
        check("cnt0_unchanged", cnt0, 0);
        drive(1'b1, 1'b0, 1'b1);
        step();
        drive(1'b0, 1'b0, 1'b0);
        step();
        check("cnt0_one", cnt0, 1);
`endif

        // Mid-stream reset with both channels holding words
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b1);
        step();
        drive(1'b1, 1'b1, 1'b1);
        step();
        check("mid_v0", out0_valid, 1);
        check("mid_v1", out1_valid, 1);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b1);
        check("mid_rst_in_ready", in_ready, 0);
        step();
        check("mid_rst_v0", out0_valid, 0);
        check("mid_rst_v1", out1_valid, 0);
        check("mid_rst_d0", out0_data, 0);
        check("mid_rst_d1", out1_data, 0);
`ifdef DEMUX_CNT_EN
        check("mid_rst_cnt0", cnt0, 0);
        check("mid_rst_cnt1", cnt1, 0);
`endif
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        step();
        check("mid_after_v0", out0_valid, 0);
        check("mid_after_v1", out1_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_demux1to2_buf
